openhw_ahbsram_sub: RTL
=======================

# openhw_ahbsram_sub

AHB-Lite subordinate that lets an on-chip synchronous single-port SRAM answer single and burst transfers from the cache/uncached bus initiator. It is the responder end of the bus-cache FSM's AHB interface. It sits behind the AHB address decoder, converts address/data phases into SRAM enables and byte writes, and generates HREADYOUT/HRESP. It supports zero-wait operation, optional programmable wait states, a one-cycle write→read port-conflict stall, and the two-cycle AHB ERROR response for out-of-range addresses.

## Interface
Parameters:
- P_AHBW, 64, data bus width in bits (power of two, ≥32)
- PA_BITS, 32, HADDR width
- RAM_ADDR_BITS, 10, log2 of SRAM depth in words
- WAIT_STATES, 0, extra HREADYOUT-low cycles inserted per beat (0–7)

Ports:
- HCLK  in  1  clock; one clock for the block
- reset  in  1  asynchronous, active-high reset
- HSEL  in  1  decoder select
- HADDR  in  PA_BITS  address-phase address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HBURST  in  3  burst type (informational only)
- HWDATA  in  P_AHBW  write data, data phase
- HWSTRB  in  P_AHBW/8  byte strobes, data phase
- HREADY  in  1  bus-level ready (mux of all HREADYOUTs)
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  P_AHBW  read data
- RamEn  out  1  SRAM access enable
- RamWE  out  1  SRAM write
- RamAdr  out  RAM_ADDR_BITS  SRAM word address
- RamBWE  out  P_AHBW/8  SRAM byte write enables
- RamWData  out  P_AHBW  SRAM write data
- RamRData  in  P_AHBW  SRAM read data, valid one cycle after RamEn & ~RamWE

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, capture word address (HADDR[RAM_ADDR_BITS+log2(P_AHBW/8)-1 : log2(P_AHBW/8)]), HWRITE and the range-error flag.
- Range error: any HADDR bit at or above RAM_ADDR_BITS+log2(P_AHBW/8) is set.
- IDLE and BUSY transfers, and ~HSEL, receive a zero-wait OKAY. No SRAM access occurs. SEQ is treated exactly like NONSEQ; the initiator supplies every beat address.
- States:
  - IDLE: no data phase pending.
  - WAIT: wait-state countdown.
  - DATA: beat completes.
  - HAZ: port-conflict stall.
  - ERR1, ERR2: error response.
- Transitions on accept, from IDLE, DATA or ERR2:
  - error → ERR1.
  - else WAIT_STATES>0 → WAIT, with counter = WAIT_STATES-1.
  - else read accepted while the current DATA beat is a write → HAZ.
  - else → DATA.
- Other transitions:
  - No accept in DATA or ERR2 → IDLE.
  - WAIT: counter 0 → DATA, else decrement.
  - HAZ → DATA.
  - ERR1 → ERR2.
- Read issue: with zero wait and no hazard, the read is issued in the address phase (RamAdr = HADDR word field), so data returns in DATA. Otherwise it is issued from the captured address in the last WAIT cycle or in HAZ.
- Write: performed in the DATA cycle. RamEn=RamWE=1, RamAdr = captured address, RamWData=HWDATA, RamBWE=HWSTRB. Writes win the SRAM port.
- Response per state:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT, HAZ: HREADYOUT=0, HRESP=0.
  - DATA: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- HRDATA = RamRData in a read DATA cycle, else 0.
- An erroring transfer never touches SRAM.

## Timing
- Reset (async, any state) → IDLE. Outputs: HREADYOUT=1, HRESP=0, HRDATA=0, RamEn=0, RamWE=0, RamBWE=0. An in-flight write is dropped; no partial write occurs.
- Zero-wait read or write: data phase completes in the cycle after address phase. A back-to-back burst of N beats takes N+1 cycles.
- WAIT_STATES=W: each beat has W low cycles, then 1 ready cycle.
- Write followed by read (W=0): the read data phase costs exactly one extra cycle (HAZ). Read→write and write→write need no stall.
- ERROR: two cycles. A new transfer may be accepted in ERR2 (HREADY high), not in ERR1.
- HREADY low from another subordinate with HSEL: no accept, state holds in IDLE.

## Structure
- Shared package openhw_ahb_pkg: ahbtranstype enum (IDLE/BUSY/NONSEQ/SEQ), HBURST encodings (SINGLE, INCR, INCR4/8/16), HRESP constants. The same package is imported by the bus-cache initiator FSM.
- One sub-module: openhw_ahbsram_sub_addrreg, the address-phase capture register (word address, write flag, error flag), enabled on accept, async reset to 0.
- FSM and wait counter stay in the top module.

## Test plan
- W=0, INCR4 write to 0x40..0x58 (data 0x11..0x44, all strobes), then INCR4 read of the same addresses → 5 cycles each, HRDATA returns 0x11,0x22,0x33,0x44, HRESP=0.
- NONSEQ write 0x100, then immediately NONSEQ read 0x100 → exactly one HREADYOUT-low cycle (HAZ), then HRDATA = written value.
- HWSTRB=0x0F write of 0xFFFF_FFFF_FFFF_FFFF over 0 → read gives 0x0000_0000_FFFF_FFFF.
- HADDR=0x0001_0000 (out of range, RAM_ADDR_BITS=10) → HREADYOUT 0/1 with HRESP 1/1, RamEn stays 0. Next NONSEQ accepted in ERR2 completes with OKAY.
- WAIT_STATES=2, single read → 2 low cycles, then ready with correct data. An IDLE/BUSY beat mid-burst → immediate OKAY, no RamEn.
- reset asserted in WAIT of a write → next cycle HREADYOUT=1, RamEn=0, SRAM location unchanged.

Source files
------------

// File: rtl/openhw_ahb_pkg.sv
// AHB-Lite encodings shared by the bus-cache initiator FSM and the SRAM subordinate.
package openhw_ahb_pkg;

    typedef enum logic [1:0] {
        AHB_IDLE   = 2'b00,
        AHB_BUSY   = 2'b01,
        AHB_NONSEQ = 2'b10,
        AHB_SEQ    = 2'b11
    } ahbtranstype;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic trans_active(input ahbtranstype t);
        return (t == AHB_NONSEQ) || (t == AHB_SEQ);
    endfunction

endpackage

// File: rtl/openhw_ahbsram_sub_addrreg.sv
// Address-phase capture: holds word address, direction and range-error flag
// for the transfer currently in its data phase.
module openhw_ahbsram_sub_addrreg #(
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [RAM_ADDR_BITS-1:0] addr,
    input  logic                     write,
    input  logic                     err,
    output logic [RAM_ADDR_BITS-1:0] cap_addr,
    output logic                     cap_write,
    output logic                     cap_err
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
        end else if (en) begin
            cap_addr  <= addr;
            cap_write <= write;
            cap_err   <= err;
        end
    end

endmodule

// File: rtl/openhw_ahbsram_sub.sv
// AHB-Lite subordinate fronting a single-port synchronous SRAM: zero-wait beats,
// optional wait states, a write->read port-conflict stall and the two-cycle ERROR.
module openhw_ahbsram_sub
    import openhw_ahb_pkg::*;
#(
    parameter int P_AHBW        = 64,
    parameter int PA_BITS       = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     HCLK,
    input  logic                     reset,
    input  logic                     HSEL,
    input  logic [PA_BITS-1:0]       HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HBURST,
    input  logic [P_AHBW-1:0]        HWDATA,
    input  logic [P_AHBW/8-1:0]      HWSTRB,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [P_AHBW-1:0]        HRDATA,
    output logic                     RamEn,
    output logic                     RamWE,
    output logic [RAM_ADDR_BITS-1:0] RamAdr,
    output logic [P_AHBW/8-1:0]      RamBWE,
    output logic [P_AHBW-1:0]        RamWData,
    input  logic [P_AHBW-1:0]        RamRData
);

    localparam int BYTE_BITS = $clog2(P_AHBW / 8);
    localparam int WORD_TOP  = RAM_ADDR_BITS + BYTE_BITS;
    localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_HAZ, S_ERR1, S_ERR2} state_t;

    state_t                   state, state_n;
    logic [2:0]               cnt, cnt_n;
    logic                     accept, addr_err, can_accept, write_beat;
    logic [RAM_ADDR_BITS-1:0] addr_word, cap_addr;
    logic                     cap_write, cap_err;
    logic                     unused_bits;

    assign addr_word   = HADDR[WORD_TOP-1:BYTE_BITS];
    assign addr_err    = |HADDR[PA_BITS-1:WORD_TOP];
    assign can_accept  = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept      = HSEL && HREADY && trans_active(ahbtranstype'(HTRANS)) && can_accept;
    assign write_beat  = (state == S_DATA) && cap_write && !cap_err;
    assign unused_bits = ^{HBURST, HADDR[BYTE_BITS-1:0]};

    openhw_ahbsram_sub_addrreg #(
        .RAM_ADDR_BITS(RAM_ADDR_BITS)
    ) u_addrreg (
        .clk      (HCLK),
        .reset    (reset),
        .en       (accept),
        .addr     (addr_word),
        .write    (HWRITE),
        .err      (addr_err),
        .cap_addr (cap_addr),
        .cap_write(cap_write),
        .cap_err  (cap_err)
    );

    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        RamEn     = 1'b0;
        RamWE     = 1'b0;
        RamAdr    = cap_addr;
        RamBWE    = '0;
        RamWData  = HWDATA;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (state == S_ERR2) HRESP = HRESP_ERROR;
                if (state == S_DATA && !cap_write) HRDATA = RamRData;
                if (write_beat) begin
                    RamEn  = 1'b1;
                    RamWE  = 1'b1;
                    RamBWE = HWSTRB;
                end
                if (accept) begin
                    if (addr_err) begin
                        state_n = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_INIT;
                    end else if (!HWRITE && write_beat) begin
                        // The port is busy with this cycle's write; re-issue the read next cycle.
                        state_n = S_HAZ;
                    end else begin
                        state_n = S_DATA;
                        if (!HWRITE) begin
                            RamEn  = 1'b1;
                            RamAdr = addr_word;
                        end
                    end
                end else if (state != S_IDLE) begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 3'd0) begin
                    state_n = S_DATA;
                    RamEn   = !cap_write;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            S_HAZ: begin
                HREADYOUT = 1'b0;
                RamEn     = 1'b1;
                state_n   = S_DATA;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_n   = S_ERR2;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
